// File: rtl/vend_seq_fsm.sv
// Vending-transaction sequencer: collects coins against PRICE, runs the dispense
// handshake, then the change handshake. State is exported in binary and one-hot.
module vend_seq_fsm #(
    parameter int PRICE    = 30,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                dispense_ack,
    input  logic                change_ack,
    output logic                dispense_req,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic [1:0]          state_binary,
    output logic [3:0]          state_onehot
);

    // Handshakes: dispense_req/change_valid are held for the whole of their state;
    // the first cycle the matching ack is sampled high completes the transfer.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   change_q, change_d;
    logic                  reject_q, reject_d;
    logic [CREDIT_W-1:0]   coin_val;
    logic                  good_coin;
    logic [CREDIT_W-1:0]   credit_sum;
    logic [CREDIT_W-1:0]   overpay;

    always_comb begin
        coin_val = '0;
        case (coin_type)
            2'b00:   coin_val = CREDIT_W'(5);
            2'b01:   coin_val = CREDIT_W'(10);
            2'b10:   coin_val = CREDIT_W'(25);
            default: coin_val = '0;
        endcase
    end

    assign good_coin  = coin_valid && (coin_type != 2'b11);
    assign credit_sum = credit_q + coin_val;
    assign overpay    = credit_q - PRICE_C;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (good_coin) begin
                    credit_d = coin_val;
                    state_d  = (coin_val >= PRICE_C) ? S_DISPENSE : S_COLLECT;
                end else begin
                    reject_d = coin_valid;
                end
            end
            S_COLLECT: begin
                // cancel takes priority: any coin in the same cycle is bounced
                if (cancel) begin
                    change_d = credit_q;
                    credit_d = '0;
                    reject_d = coin_valid;
                    state_d  = S_CHANGE;
                end else if (good_coin) begin
                    credit_d = credit_sum;
                    if (credit_sum >= PRICE_C) state_d = S_DISPENSE;
                end else begin
                    reject_d = coin_valid;
                end
            end
            S_DISPENSE: begin
                reject_d = coin_valid;
                if (dispense_ack) begin
                    credit_d = '0;
                    if (overpay != '0) begin
                        change_d = overpay;
                        state_d  = S_CHANGE;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (change_ack) begin
                    change_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            change_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            reject_q <= reject_d;
        end
    end

    assign dispense_req = (state_q == S_DISPENSE);
    assign change_valid = (state_q == S_CHANGE);
    assign change_amt   = change_q;
    assign credit       = credit_q;
    assign coin_reject  = reject_q;
    assign state_binary = state_q;
    assign state_onehot = 4'b0001 << state_q;

endmodule

// File: tb/tb_vend_seq_fsm.sv
// Self-checking bench for vend_seq_fsm: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_vend_seq_fsm;

    localparam int PRICE    = 30;
    localparam int CREDIT_W = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin_type = 2'b00;
    logic                cancel = 1'b0;
    logic                dispense_ack = 1'b0;
    logic                change_ack = 1'b0;
    logic                dispense_req;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic [1:0]          state_binary;
    logic [3:0]          state_onehot;

    int n_checks = 0;
    int n_fail   = 0;

    // model: credit held, sale committed, refund owed, reject pulse pending
    int m_credit = 0;
    bit m_sale   = 0;
    int m_refund = 0;
    bit m_reject = 0;

    vend_seq_fsm #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .change_ack   (change_ack),
        .dispense_req (dispense_req),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .state_binary (state_binary),
        .state_onehot (state_onehot)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The phase of the transaction follows from what the machine owes.
    function automatic int model_phase();
        if (m_refund > 0) return 3;
        if (m_sale)       return 2;
        if (m_credit > 0) return 1;
        return 0;
    endfunction

    function automatic int coin_cents(input bit [1:0] ct);
        case (ct)
            2'b00:   return 5;
            2'b01:   return 10;
            2'b10:   return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit cv, input bit [1:0] ct, input bit cn,
                              input bit da, input bit ca);
        bit good;
        good     = cv && (ct != 2'b11);
        m_reject = 1'b0;
        if (m_refund > 0) begin
            m_reject = cv;
            if (ca) m_refund = 0;
        end else if (m_sale) begin
            m_reject = cv;
            if (da) begin
                m_refund = m_credit - PRICE;
                m_credit = 0;
                m_sale   = 1'b0;
            end
        end else if (m_credit > 0 && cn) begin
            m_refund = m_credit;
            m_credit = 0;
            m_reject = cv;
        end else if (good) begin
            m_credit = m_credit + coin_cents(ct);
            if (m_credit >= PRICE) m_sale = 1'b1;
        end else begin
            m_reject = cv;
        end
    endtask

    task automatic compare_all();
        int ph;
        ph = model_phase();
        check_val("state_binary", int'(state_binary), ph);
        check_val("state_onehot", int'(state_onehot), 1 << ph);
        check_val("credit", int'(credit), m_credit);
        check_val("change_amt", int'(change_amt), m_refund);
        check_val("dispense_req", int'(dispense_req), int'(ph == 2));
        check_val("change_valid", int'(change_valid), int'(ph == 3));
        check_val("coin_reject", int'(coin_reject), int'(m_reject));
    endtask

    task automatic step(input bit cv, input bit [1:0] ct, input bit cn,
                        input bit da, input bit ca);
        @(negedge clk);
        coin_valid   = cv;
        coin_type    = ct;
        cancel       = cn;
        dispense_ack = da;
        change_ack   = ca;
        @(posedge clk);
        model_step(cv, ct, cn, da, ca);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        coin_valid   = 1'b0;
        cancel       = 1'b0;
        dispense_ack = 1'b0;
        change_ack   = 1'b0;
        @(posedge clk);
        m_credit = 0;
        m_sale   = 1'b0;
        m_refund = 0;
        m_reject = 1'b0;
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic idle_cycle();
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        check_val("rst_onehot", int'(state_onehot), 1);

        // exact pay: three dimes then dispense ack
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check_val("exact_credit1", int'(credit), 10);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check_val("exact_credit2", int'(credit), 20);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check_val("exact_credit3", int'(credit), 30);
        check_val("exact_req", int'(dispense_req), 1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_val("exact_idle", int'(state_binary), 0);
        check_val("exact_no_change", int'(change_valid), 0);

        // overpay: dime + quarter, change of 5
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_val("over_credit", int'(credit), 35);
        idle_cycle();
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_val("over_change_amt", int'(change_amt), 5);
        check_val("over_change_state", int'(state_binary), 3);
        idle_cycle();
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("over_idle", int'(state_binary), 0);

        // reset mid-change
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_val("pre_rst_change", int'(change_amt), 5);
        do_reset();
        check_val("rst_mid_onehot", int'(state_onehot), 1);
        check_val("rst_mid_valid", int'(change_valid), 0);

        // cancel with a coarse coin in the same cycle
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        check_val("cancel_reject", int'(coin_reject), 1);
        check_val("cancel_amt", int'(change_amt), 10);
        check_val("cancel_credit", int'(credit), 0);
        idle_cycle();
        check_val("cancel_reject_once", int'(coin_reject), 0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // rejects: invalid coin in IDLE, quarter during DISPENSE
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        check_val("rej_idle", int'(coin_reject), 1);
        check_val("rej_idle_credit", int'(credit), 0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_val("rej_disp", int'(coin_reject), 1);
        check_val("rej_disp_credit", int'(credit), 30);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit       cv, cn, da, ca;
            bit [1:0] ct;
            cv = ($urandom_range(0, 2) == 0);
            ct = 2'($urandom_range(0, 3));
            cn = ($urandom_range(0, 7) == 0);
            da = ($urandom_range(0, 3) == 0);
            ca = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(cv, ct, cn, da, ca);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_seq_fsm.md
# vend_seq_fsm

Vending-transaction sequencer for the digital vending machine. It accepts coins, accumulates credit against a fixed price, and requests a dispense through a req/ack handshake. It then returns change through a second req/ack handshake. The current state is exported in both binary and one-hot encodings for the display and debug logic.

## Interface
Parameters:
- PRICE, default 30: item price in cents; must be a multiple of 5 and at least 5.
- CREDIT_W, default 6: width of the credit and change fields; PRICE+20 must be ≤ 2^CREDIT_W − 1.

Ports:
- clk  in  1  the single clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- coin_valid  in  1  one-cycle coin strobe.
- coin_type  in  2  coin value: 00 = 5, 01 = 10, 10 = 25, 11 = invalid.
- cancel  in  1  request a refund of the current credit.
- dispense_ack  in  1  the dispenser has released the item.
- change_ack  in  1  the coin return has paid out change_amt.
- dispense_req  out  1  high for the whole time the FSM is in DISPENSE.
- change_valid  out  1  high for the whole time the FSM is in CHANGE.
- change_amt  out  CREDIT_W  amount to refund; stable while change_valid is high.
- credit  out  CREDIT_W  accumulated credit.
- coin_reject  out  1  registered one-cycle pulse; flags a coin that was not accepted.
- state_binary  out  2  IDLE = 0, COLLECT = 1, DISPENSE = 2, CHANGE = 3.
- state_onehot  out  4  equals 1 << state_binary.

## Operation
- All outputs are registered or are decodes of registered state.
- Reset values:
  - state = IDLE, so state_binary = 0 and state_onehot = 4'b0001.
  - credit = 0 and change_amt = 0.
  - dispense_req, change_valid and coin_reject are all 0.
- A "good coin" is coin_valid = 1 with coin_type ≠ 11.
- An invalid coin (type 11) is rejected in every state.
- IDLE:
  - A good coin sets credit = value.
  - If value ≥ PRICE, go to DISPENSE; otherwise go to COLLECT.
  - cancel is ignored.
- COLLECT:
  - A good coin sets credit = credit + value.
  - If the new credit ≥ PRICE, go to DISPENSE.
  - If cancel = 1: set change_amt = credit and go to CHANGE. Any coin in the same cycle is rejected, because cancel wins.
- DISPENSE:
  - Hold dispense_req until dispense_ack is sampled high.
  - On ack, compute change = credit − PRICE and clear credit to 0.
  - If change > 0, load change_amt and go to CHANGE; otherwise go to IDLE.
  - Every coin is rejected.
  - cancel is ignored, because the sale is committed.
- CHANGE:
  - Hold change_valid and change_amt until change_ack is sampled high.
  - Then go to IDLE and clear change_amt to 0.
  - Every coin is rejected, and cancel is ignored.
  - If the FSM entered CHANGE from a cancel, credit is cleared when it enters CHANGE.
- Arithmetic is unsigned at CREDIT_W bits. The parameter constraint guarantees no overflow: the maximum credit is PRICE − 5 + 25.
- An ack received in any other state is ignored.
- rst asserted in any state, including mid-handshake, restores the reset values on the next edge. In-flight credit is discarded.

## Timing
- Every state transition takes effect on the edge after the qualifying input is sampled.
- credit updates on the same edge that the coin is accepted.
- coin_reject goes high on the edge after the rejected coin and lasts exactly one cycle.
- From the edge on which credit reaches PRICE, dispense_req is high starting on that same edge.
- Minimum-latency transaction with exact payment: coin → DISPENSE (1 cycle) → ack → IDLE (1 cycle).
- The acks may be held high for multiple cycles. Only the first sample in the matching state is used, and the FSM leaves that state on the following edge.
- state_binary and state_onehot change on the same edge and always agree.

## Test plan
- Reset:
  - Stimulus: assert rst mid-CHANGE with change_amt = 5.
  - Required response: next cycle, state_onehot = 0001, credit = 0, change_valid = 0.
- Exact pay:
  - Stimulus: dime, dime, dime; then dispense_ack.
  - Required response: credit steps 10 → 20 → 30; dispense_req is high in the cycle after the third dime; after the ack, state = IDLE, change_valid never asserts, credit = 0.
- Overpay:
  - Stimulus: dime, then quarter (credit 35); then dispense_ack; then change_ack.
  - Required response: after the dispense ack, CHANGE with change_amt = 5; after the change ack, IDLE.
- Cancel:
  - Stimulus: nickel, nickel, then cancel together with a quarter in the same cycle.
  - Required response: coin_reject pulses once; CHANGE with change_amt = 10; credit = 0.
- Reject:
  - Stimulus: coin_type 11 in IDLE; a quarter during DISPENSE.
  - Required response: each gives a one-cycle coin_reject; credit is unchanged by both.
- Encoding:
  - Stimulus: any sequence that visits all four states.
  - Required response: state_onehot == 1 << state_binary checked on every cycle.
